// File: rtl/cascade_cache_banked.sv
// cascade_cache_banked
//   On-chip store for Viola-Jones cascade stage/feature words. A sequencer loads the
//   cascade once through an auto-addressed handshake. NUM_READ classifier lanes then
//   read it in parallel. Each read port owns a RAM bank, and every bank takes every
//   write, so the lanes never contend for a port.
//
// Ports
//   clk, rst     single clock; synchronous active-high reset
//   load_start   begin a (re)load; clears word_count and has priority over load_valid
//   load_valid   load_data is valid this cycle
//   load_last    marks the final word of the load
//   load_data    cascade word
//   load_ready   high in LOAD; a word is accepted when load_valid & load_ready
//   cache_ready  high in READY; the cascade is fully loaded
//   word_count   words written since the last load_start (saturates at WORDS)
//   rd_en        per-port read request
//   rd_addr      port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_q         port i at [i*WORD_SIZE +: WORD_SIZE]; holds while rd_valid is low
//   rd_valid     rd_en delayed by 1+OUT_REG cycles
module cascade_cache_banked #(
    parameter int unsigned WORD_SIZE  = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned WORDS      = 1024,
    parameter int unsigned NUM_READ   = 2,
    parameter int unsigned OUT_REG    = 0,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load_start,
    input  logic                           load_valid,
    input  logic                           load_last,
    input  logic [WORD_SIZE-1:0]           load_data,
    output logic                           load_ready,
    output logic                           cache_ready,
    output logic [ADDR_WIDTH:0]            word_count,
    input  logic [NUM_READ-1:0]            rd_en,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_READ*WORD_SIZE-1:0]  rd_q,
    output logic [NUM_READ-1:0]            rd_valid
);

    // Bits needed to index the physical array; high address bits beyond this only
    // matter for the bypass compare.
    localparam int unsigned MemAw = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [ADDR_WIDTH:0] LastAddr = (ADDR_WIDTH + 1)'(WORDS - 1);
    localparam logic [ADDR_WIDTH:0] CountOne = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StReady
    } state_e;

    state_e state_q;

    // A word is written only in LOAD, never in the cycle of a load_start or a reset.
    logic accept;
    assign accept = (state_q == StLoad) && load_valid && !load_start && !rst;

    // Load sequencer: state plus registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            load_ready  <= 1'b0;
            cache_ready <= 1'b0;
            word_count  <= '0;
        end else if (load_start) begin
            state_q     <= StLoad;
            load_ready  <= 1'b1;
            cache_ready <= 1'b0;
            word_count  <= '0;
        end else if (accept) begin
            word_count <= word_count + CountOne;
            // Stopping at the last physical address is what makes the count saturate
            // at WORDS.
            if (load_last || (word_count == LastAddr)) begin
                state_q     <= StReady;
                load_ready  <= 1'b0;
                cache_ready <= 1'b1;
            end
        end
    end

    logic [MemAw-1:0]      wr_addr;
    logic [ADDR_WIDTH-1:0] wr_addr_full;
    assign wr_addr      = word_count[MemAw-1:0];
    assign wr_addr_full = word_count[ADDR_WIDTH-1:0];

    for (genvar i = 0; i < NUM_READ; i++) begin : g_bank
        logic [WORD_SIZE-1:0]  mem [WORDS];
        logic [ADDR_WIDTH-1:0] addr;
        logic                  hit;
        logic                  s1_valid;
        logic [WORD_SIZE-1:0]  s1_data;
        logic                  out_valid;
        logic [WORD_SIZE-1:0]  out_data;

        assign addr = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];

        // Same-cycle read of the address being written returns the new word.
        assign hit = (BYPASS != 0) && accept && (addr == wr_addr_full);

        // Contents survive reset; only the write port updates them.
        always_ff @(posedge clk) begin
            if (accept) begin
                mem[wr_addr] <= load_data;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                s1_valid <= 1'b0;
                s1_data  <= '0;
            end else begin
                s1_valid <= rd_en[i];
                if (rd_en[i]) begin
                    s1_data <= hit ? load_data : mem[addr[MemAw-1:0]];
                end
            end
        end

        if (OUT_REG != 0) begin : g_oreg
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid <= 1'b0;
                    out_data  <= '0;
                end else begin
                    out_valid <= s1_valid;
                    if (s1_valid) begin
                        out_data <= s1_data;
                    end
                end
            end
        end else begin : g_noreg
            assign out_valid = s1_valid;
            assign out_data  = s1_data;
        end

        assign rd_valid[i]                     = out_valid;
        assign rd_q[i*WORD_SIZE +: WORD_SIZE] = out_data;
    end

endmodule

// File: tb/tb_cascade_cache_banked.sv
// Bench for cascade_cache_banked. Two instances share one stimulus stream: one
// with latency 1 (OUT_REG=0) and one with latency 2 (OUT_REG=1), both WORDS=16
// and BYPASS=1. Reads push expected words with their due cycle into a scoreboard;
// a negedge monitor pops and compares whenever a DUT raises rd_valid.
module tb_cascade_cache_banked;

    localparam int AW    = 10;
    localparam int W     = 32;
    localparam int NR    = 2;
    localparam int WORDS = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              load_start = 1'b0;
    logic              load_valid = 1'b0;
    logic              load_last = 1'b0;
    logic [W-1:0]      load_data = '0;
    logic [NR-1:0]     rd_en = '0;
    logic [NR*AW-1:0]  rd_addr = '0;

    logic              lr [2];
    logic              cr [2];
    logic [AW:0]       wc [2];
    logic [NR*W-1:0]   q  [2];
    logic [NR-1:0]     v  [2];

    always #5 clk = ~clk;

    cascade_cache_banked #(
        .WORD_SIZE(W), .ADDR_WIDTH(AW), .WORDS(WORDS), .NUM_READ(NR), .OUT_REG(0), .BYPASS(1)
    ) u_lat1 (
        .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
        .load_last(load_last), .load_data(load_data), .load_ready(lr[0]),
        .cache_ready(cr[0]), .word_count(wc[0]), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_q(q[0]), .rd_valid(v[0])
    );

    cascade_cache_banked #(
        .WORD_SIZE(W), .ADDR_WIDTH(AW), .WORDS(WORDS), .NUM_READ(NR), .OUT_REG(1), .BYPASS(1)
    ) u_lat2 (
        .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
        .load_last(load_last), .load_data(load_data), .load_ready(lr[1]),
        .cache_ready(cr[1]), .word_count(wc[1]), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_q(q[1]), .rd_valid(v[1])
    );

    typedef struct {
        int          inst;
        int          port;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_status(input string tag, input logic el, input logic ec, input int ew);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s.load_ready[%0d]", tag, k), 32'(lr[k]), 32'(el));
            chk($sformatf("%s.cache_ready[%0d]", tag, k), 32'(cr[k]), 32'(ec));
            chk($sformatf("%s.word_count[%0d]", tag, k), 32'(wc[k]), ew);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rd_en = '0;
    endtask

    // mask bit k selects which instances are expected to answer.
    task automatic issue_read(input int port, input int addr, input logic [31:0] data,
                              input int mask);
        exp_t e;
        rd_en[port]             = 1'b1;
        rd_addr[port*AW +: AW]  = addr[AW-1:0];
        for (int k = 0; k < 2; k++) begin
            if (mask[k]) begin
                e.inst = k;
                e.port = port;
                e.data = data;
                e.due  = cyc + 1 + k;
                sb.push_back(e);
            end
        end
    endtask

    always @(negedge clk) begin : monitor
        int idx;
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < NR; p++) begin
                if (v[k][p] === 1'b1) begin
                    idx = -1;
                    for (int j = 0; j < sb.size(); j++) begin
                        if (sb[j].inst == k && sb[j].port == p) begin
                            idx = j;
                            break;
                        end
                    end
                    checks++;
                    if (idx < 0) begin
                        errors++;
                        $display("FAIL unexpected_valid inst%0d port%0d: got data %0h at cycle %0d, required no valid",
                                 k, p, q[k][p*W +: W], cyc);
                    end else begin
                        if (q[k][p*W +: W] !== sb[idx].data || sb[idx].due != cyc) begin
                            errors++;
                            $display("FAIL read inst%0d port%0d: got %0h at cycle %0d, required %0h at cycle %0d",
                                     k, p, q[k][p*W +: W], cyc, sb[idx].data, sb[idx].due);
                        end
                        sb.delete(idx);
                    end
                end
            end
        end
        for (int j = sb.size() - 1; j >= 0; j--) begin
            if (sb[j].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_valid inst%0d port%0d: got no valid, required %0h at cycle %0d",
                         sb[j].inst, sb[j].port, sb[j].data, sb[j].due);
                sb.delete(j);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    initial begin
        // Reset
        rst = 1'b1;
        tick();
        tick();
        chk_status("reset", 1'b0, 1'b0, 0);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset.rd_valid[%0d]", k), 32'(v[k]), 32'd0);
            chk($sformatf("reset.rd_q_lo[%0d]", k), q[k][31:0], 32'd0);
            chk($sformatf("reset.rd_q_hi[%0d]", k), q[k][63:32], 32'd0);
        end
        rst = 1'b0;

        // T1: eight words with load_last on the eighth
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk_status("t1_start", 1'b1, 1'b0, 0);
        for (int i = 0; i < 8; i++) begin
            load_valid = 1'b1;
            load_data  = 32'hA0 + 32'(i);
            load_last  = (i == 7);
            tick();
            if (i == 6) chk_status("t1_word7", 1'b1, 1'b0, 7);
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        chk_status("t1_done", 1'b0, 1'b1, 8);

        // T2: parallel reads, same-address reads, back-to-back reads
        issue_read(0, 3, 32'hA3, 3);
        issue_read(1, 5, 32'hA5, 3);
        tick();
        issue_read(0, 7, 32'hA7, 3);
        issue_read(1, 7, 32'hA7, 3);
        tick();
        issue_read(0, 0, 32'hA0, 3);
        tick();
        issue_read(0, 1, 32'hA1, 3);
        tick();
        tick();
        tick();

        // T6: load_start in READY with a simultaneous word, which must be dropped
        load_start = 1'b1;
        load_valid = 1'b1;
        load_data  = 32'hDEAD;
        tick();
        load_start = 1'b0;
        load_valid = 1'b0;
        chk_status("t6_restart", 1'b1, 1'b0, 0);
        issue_read(0, 0, 32'hA0, 3);
        tick();

        // T4: write 0x55 to addr 2 while both ports read addr 2
        load_valid = 1'b1;
        load_data  = 32'h50;
        tick();
        load_data  = 32'h51;
        tick();
        load_data  = 32'h55;
        issue_read(0, 2, 32'h55, 3);
        issue_read(1, 2, 32'h55, 3);
        tick();

        // T3: no load_last; fills to WORDS, extra words ignored
        for (int i = 3; i < 16; i++) begin
            load_data = 32'h60 + 32'(i);
            if (i == 3) issue_read(1, 4, 32'hA4, 3);
            tick();
            if (i == 14) chk_status("t3_word15", 1'b1, 1'b0, 15);
        end
        chk_status("t3_full", 1'b0, 1'b1, 16);
        load_data = 32'hFF;
        tick();
        tick();
        load_valid = 1'b0;
        chk_status("t3_extra", 1'b0, 1'b1, 16);
        issue_read(0, 15, 32'h6F, 3);
        issue_read(1, 2, 32'h55, 3);
        tick();
        issue_read(0, 0, 32'h50, 3);
        issue_read(1, 14, 32'h6E, 3);
        tick();
        tick();
        tick();

        // T5: reset after three words; in-flight latency-2 read is killed
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        load_valid = 1'b1;
        load_data  = 32'hB0;
        tick();
        load_data  = 32'hB1;
        tick();
        load_data  = 32'hB2;
        issue_read(1, 1, 32'hB1, 1);
        tick();
        load_valid = 1'b0;
        rst        = 1'b1;
        rd_en[0]   = 1'b1;
        tick();
        chk_status("t5_rst", 1'b0, 1'b0, 0);
        rst = 1'b0;
        tick();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            load_valid = 1'b1;
            load_data  = 32'hC0 + 32'(i);
            load_last  = (i == 7);
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        chk_status("t5_reload", 1'b0, 1'b1, 8);
        issue_read(0, 7, 32'hC7, 3);
        issue_read(1, 4, 32'hC4, 3);
        tick();
        issue_read(0, 8, 32'h68, 3);
        tick();
        for (int i = 0; i < 4; i++) tick();

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
